// File: rtl/rv32i_pkg.sv
// rv32i_pkg -- shared definitions for the RV32I/RV32E register file.
//   XLEN_DEFAULT : default register data width
//   NREG_RV32E   : register count for the embedded (16-entry) variant
//   NREG_RV32I   : register count for the full (32-entry) variant
//   rf_state_e   : register-file controller states (INIT clears storage,
//                  READY is normal operation)
package rv32i_pkg;

  localparam int unsigned XLEN_DEFAULT = 32;
  localparam int unsigned NREG_RV32E   = 16;
  localparam int unsigned NREG_RV32I   = 32;

  typedef enum logic [0:0] {
    INIT  = 1'b0,
    READY = 1'b1
  } rf_state_e;

endpackage

// File: rtl/rv32i_regfile_rdport.sv
// rv32i_regfile_rdport -- one registered read port of the register file.
// Ports:
//   clk, reset   : clock, asynchronous active-high reset
//   ready_i      : register file is in normal operation (storage valid)
//   wb_enable_i  : write-back strobe of the same cycle
//   wb_reg_i     : write-back register index
//   wb_data_i    : write-back data (bypass source)
//   rd_reg_i     : register index read by this port
//   rd_mem_i     : storage contents at rd_reg_i
//   rd_data_o    : registered read data
module rv32i_regfile_rdport
#(
  parameter int unsigned XLEN = 32,
  parameter int unsigned AW   = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            ready_i,
  input  logic            wb_enable_i,
  input  logic [AW-1:0]   wb_reg_i,
  input  logic [XLEN-1:0] wb_data_i,
  input  logic [AW-1:0]   rd_reg_i,
  input  logic [XLEN-1:0] rd_mem_i,
  output logic [XLEN-1:0] rd_data_o
);

  logic            rd_is_x0_s;
  logic            bypass_s;
  logic [XLEN-1:0] rd_data_d;
  logic [XLEN-1:0] rd_data_q;

  assign rd_is_x0_s = (rd_reg_i == {AW{1'b0}});
  // A write landing on the register being read wins; x0 is never bypassed.
  assign bypass_s   = wb_enable_i && (wb_reg_i == rd_reg_i) && !rd_is_x0_s;

  // Select next read value: zero while clearing, bypass, hard-wired x0, storage.
  always_comb begin
    rd_data_d = {XLEN{1'b0}};
    if (!ready_i) begin
      rd_data_d = {XLEN{1'b0}};
    end else if (bypass_s) begin
      rd_data_d = wb_data_i;
    end else if (rd_is_x0_s) begin
      rd_data_d = {XLEN{1'b0}};
    end else begin
      rd_data_d = rd_mem_i;
    end
  end

  // Output register: no combinational path from inputs to rd_data_o.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_data_q <= {XLEN{1'b0}};
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/rv32i_regfile_mp.sv
// rv32i_regfile_mp -- multi-read-port RISC-V integer register file.
// After reset an INIT sequence zeroes x1..x(NREG-1), one register per edge,
// then 'ready' rises. Storage has no reset so it can map onto RAM.
// Parameters: XLEN data width, NREG register count (16 or 32), NRD read ports (1..4).
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   wb_enable, wb_reg, wb_data : single write-back port (ignored during INIT)
//   rs_reg[NRD]  : read indices;  rs_data[NRD] : registered read data
//   ready        : high once the clear sequence has completed
// Optional (macro RV32I_REGFILE_DBG_EN): dbg_reg / dbg_data combinational
//   debug read, x0 reads 0, no write bypass.
module rv32i_regfile_mp
  import rv32i_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEFAULT,
  parameter int unsigned NREG = NREG_RV32I,
  parameter int unsigned NRD  = 2,
  localparam int unsigned AW  = $clog2(NREG)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      wb_enable,
  input  logic [AW-1:0]             wb_reg,
  input  logic [XLEN-1:0]           wb_data,
  input  logic [NRD-1:0][AW-1:0]    rs_reg,
  output logic [NRD-1:0][XLEN-1:0]  rs_data,
  output logic                      ready
`ifdef RV32I_REGFILE_DBG_EN
  ,
  input  logic [AW-1:0]             dbg_reg,
  output logic [XLEN-1:0]           dbg_data
`endif
);

  localparam logic [AW-1:0] IDX_FIRST = AW'(1);
  localparam logic [AW-1:0] IDX_LAST  = AW'(NREG - 1);

  rf_state_e       state_q, state_d;
  logic [AW-1:0]   idx_q, idx_d;
  logic            ready_q, ready_d;
  logic            mem_we_s;
  logic [AW-1:0]   mem_waddr_s;
  logic [XLEN-1:0] mem_wdata_s;
  logic [XLEN-1:0] mem_q [NREG];

  // Controller state register, clear counter and ready flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= INIT;
      idx_q   <= IDX_FIRST;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ready_q <= ready_d;
    end
  end

  // Next-state logic: walk idx up to the last register, then enter READY.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      INIT: begin
        if (idx_q == IDX_LAST) begin
          state_d = READY;
        end else begin
          idx_d = idx_q + AW'(1);
        end
      end
      READY: begin
        state_d = READY;
      end
      default: begin
        state_d = INIT;
        idx_d   = IDX_FIRST;
      end
    endcase
  end

  // Output logic: storage write port is the clear walker in INIT, write-back in READY.
  always_comb begin
    ready_d     = 1'b0;
    mem_we_s    = 1'b0;
    mem_waddr_s = idx_q;
    mem_wdata_s = {XLEN{1'b0}};
    case (state_q)
      INIT: begin
        // ready rises on the same edge that clears the last register
        ready_d     = (idx_q == IDX_LAST);
        mem_we_s    = 1'b1;
        mem_waddr_s = idx_q;
        mem_wdata_s = {XLEN{1'b0}};
      end
      READY: begin
        ready_d     = 1'b1;
        mem_we_s    = wb_enable && (wb_reg != {AW{1'b0}});
        mem_waddr_s = wb_reg;
        mem_wdata_s = wb_data;
      end
      default: begin
        ready_d  = 1'b0;
        mem_we_s = 1'b0;
      end
    endcase
  end

  // Register storage: no reset, zeroed only by the INIT walk.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_q[mem_waddr_s] <= mem_wdata_s;
    end
  end

  assign ready = ready_q;

  for (genvar g = 0; g < NRD; g++) begin : g_rdport
    rv32i_regfile_rdport #(
      .XLEN (XLEN),
      .AW   (AW)
    ) u_rdport (
      .clk         (clk),
      .reset       (reset),
      .ready_i     (ready_q),
      .wb_enable_i (wb_enable),
      .wb_reg_i    (wb_reg),
      .wb_data_i   (wb_data),
      .rd_reg_i    (rs_reg[g]),
      .rd_mem_i    (mem_q[rs_reg[g]]),
      .rd_data_o   (rs_data[g])
    );
  end

`ifdef RV32I_REGFILE_DBG_EN
  // Debug read: straight from storage, x0 forced to zero, no bypass.
  always_comb begin
    if (dbg_reg == {AW{1'b0}}) begin
      dbg_data = {XLEN{1'b0}};
    end else begin
      dbg_data = mem_q[dbg_reg];
    end
  end
`endif

endmodule

// File: tb/tb_rv32i_regfile_mp.sv
// tb_rv32i_regfile_mp -- scoreboard bench for rv32i_regfile_mp (defaults:
// XLEN=32, NREG=32, NRD=2). Stimulus is applied at the falling edge and the
// expected result for the next rising edge is queued; a monitor samples just
// after each rising edge and compares against the queue.
// With RV32I_REGFILE_DBG_EN defined the debug read port is also exercised.
module tb_rv32i_regfile_mp;

  logic             clk;
  logic             reset;
  logic             wb_enable;
  logic [4:0]       wb_reg;
  logic [31:0]      wb_data;
  logic [1:0][4:0]  rs_reg;
  logic [1:0][31:0] rs_data;
  logic             ready;
`ifdef RV32I_REGFILE_DBG_EN
  logic [4:0]       dbg_reg;
  logic [31:0]      dbg_data;
`endif

  rv32i_regfile_mp #(
    .XLEN (32),
    .NREG (32),
    .NRD  (2)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .wb_enable (wb_enable),
    .wb_reg    (wb_reg),
    .wb_data   (wb_data),
    .rs_reg    (rs_reg),
    .rs_data   (rs_data),
    .ready     (ready)
`ifdef RV32I_REGFILE_DBG_EN
    ,
    .dbg_reg   (dbg_reg),
    .dbg_data  (dbg_data)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // kind: 0 = ready, 1 = rs_data[port], 2 = dbg_data
  typedef struct {
    int          due;
    int          kind;
    int          port;
    logic [31:0] exp;
  } exp_t;

  exp_t        sb_q[$];
  int          cyc = 0;
  int          n_vec = 0;
  int          n_bad = 0;
  exp_t        mon_e;
  logic [31:0] mon_act;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compare every expectation that falls due on this edge.
  always begin
    @(posedge clk);
    #1;
    while (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
      mon_e = sb_q.pop_front();
      if (mon_e.kind == 0) begin
        mon_act = {31'd0, ready};
      end else if (mon_e.kind == 1) begin
        mon_act = rs_data[mon_e.port];
      end else begin
`ifdef RV32I_REGFILE_DBG_EN
        mon_act = dbg_data;
`else
        mon_act = 32'hxxxx_xxxx;
`endif
      end
      n_vec++;
      if (mon_e.due != cyc) begin
        n_bad++;
        $display("FAIL stale kind%0d port%0d due %0d at edge %0d", mon_e.kind, mon_e.port, mon_e.due, cyc);
      end else if (mon_act !== mon_e.exp) begin
        n_bad++;
        $display("FAIL %s port%0d edge %0d: got %h expected %h",
                 (mon_e.kind == 0) ? "ready" : ((mon_e.kind == 1) ? "rs_data" : "dbg_data"),
                 mon_e.port, cyc, mon_act, mon_e.exp);
      end
    end
  end

  task automatic push(input int kind, input int port, input logic [31:0] exp);
    exp_t e;
    e.due  = cyc + 1;
    e.kind = kind;
    e.port = port;
    e.exp  = exp;
    sb_q.push_back(e);
  endtask

  // Drive one cycle of inputs and queue what the next rising edge must produce.
  task automatic apply(input logic rst, input logic we, input logic [4:0] wr, input logic [31:0] wd,
                       input logic [4:0] r0, input logic [4:0] r1,
                       input logic exp_rdy, input logic [31:0] e0, input logic [31:0] e1);
    reset     = rst;
    wb_enable = we;
    wb_reg    = wr;
    wb_data   = wd;
    rs_reg[0] = r0;
    rs_reg[1] = r1;
    push(0, 0, {31'd0, exp_rdy});
    push(1, 0, e0);
    push(1, 1, e1);
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset     = 1'b1;
    wb_enable = 1'b0;
    wb_reg    = 5'd0;
    wb_data   = 32'd0;
    rs_reg    = '{5'd0, 5'd0};
`ifdef RV32I_REGFILE_DBG_EN
    dbg_reg   = 5'd0;
`endif
    @(negedge clk);

    // Reset held, write attempts must have no effect
    repeat (2) apply(1'b1, 1'b1, 5'd5, 32'hFFFF_FFFF, 5'd5, 5'd0, 1'b0, 32'd0, 32'd0);
    // INIT: 31 edges, ready rises on the last; writes ignored, reads zero
    for (int e = 1; e <= 31; e++)
      apply(1'b0, 1'b1, 5'd5, 32'hA5A5_A5A5, 5'd5, 5'd6, (e == 31), 32'd0, 32'd0);

    // x5 was never written during INIT
    apply(1'b0, 1'b0, 5'd0, 32'd0, 5'd5, 5'd6, 1'b1, 32'd0, 32'd0);
    // Write 0x25 to x10, then read x10 / x15
    apply(1'b0, 1'b1, 5'd10, 32'h25, 5'd0, 5'd0, 1'b1, 32'd0, 32'd0);
    apply(1'b0, 1'b0, 5'd0, 32'd0, 5'd10, 5'd15, 1'b1, 32'h25, 32'd0);
    // Write 321 to x0 while reading x0: x0 stays zero
    apply(1'b0, 1'b1, 5'd0, 32'd321, 5'd0, 5'd10, 1'b1, 32'd0, 32'h25);
    apply(1'b0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b1, 32'd0, 32'd0);
    // Write 0x20 to x5 while both ports read x5: bypass on both
    apply(1'b0, 1'b1, 5'd5, 32'h20, 5'd5, 5'd5, 1'b1, 32'h20, 32'h20);
    apply(1'b0, 1'b0, 5'd0, 32'd0, 5'd5, 5'd5, 1'b1, 32'h20, 32'h20);
    // Write 0xDEADBEEF to x7 with bypass on port0 only
    apply(1'b0, 1'b1, 5'd7, 32'hDEAD_BEEF, 5'd7, 5'd10, 1'b1, 32'hDEAD_BEEF, 32'h25);
    // Bypass on port1 only
    apply(1'b0, 1'b1, 5'd9, 32'h11, 5'd10, 5'd9, 1'b1, 32'h25, 32'h11);
    // Matching index without strobe: no bypass
    apply(1'b0, 1'b0, 5'd7, 32'h0BAD_0BAD, 5'd7, 5'd9, 1'b1, 32'hDEAD_BEEF, 32'h11);
    // Write 0x1234 to x3
    apply(1'b0, 1'b1, 5'd3, 32'h1234, 5'd0, 5'd0, 1'b1, 32'd0, 32'd0);
`ifdef RV32I_REGFILE_DBG_EN
    dbg_reg = 5'd3;
    push(2, 0, 32'h1234);
    apply(1'b0, 1'b0, 5'd0, 32'd0, 5'd3, 5'd0, 1'b1, 32'h1234, 32'd0);
    dbg_reg = 5'd0;
    push(2, 0, 32'd0);
    apply(1'b0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b1, 32'd0, 32'd0);
`endif

    // Reset mid-READY, 5 INIT edges, reset again mid-INIT
    apply(1'b1, 1'b0, 5'd0, 32'd0, 5'd7, 5'd9, 1'b0, 32'd0, 32'd0);
    for (int e = 1; e <= 5; e++)
      apply(1'b0, 1'b0, 5'd0, 32'd0, 5'd7, 5'd9, 1'b0, 32'd0, 32'd0);
    repeat (2) apply(1'b1, 1'b0, 5'd0, 32'd0, 5'd7, 5'd9, 1'b0, 32'd0, 32'd0);
    // Full INIT restarts from x1: ready after exactly 31 edges
    for (int e = 1; e <= 31; e++)
      apply(1'b0, 1'b0, 5'd0, 32'd0, 5'd7, 5'd9, (e == 31), 32'd0, 32'd0);
    // Previously written registers now read zero
    apply(1'b0, 1'b0, 5'd0, 32'd0, 5'd7, 5'd9, 1'b1, 32'd0, 32'd0);
    apply(1'b0, 1'b0, 5'd0, 32'd0, 5'd10, 5'd5, 1'b1, 32'd0, 32'd0);
    apply(1'b0, 1'b0, 5'd0, 32'd0, 5'd3, 5'd0, 1'b1, 32'd0, 32'd0);

    // Drain: anything still queued was never compared
    repeat (3) @(negedge clk);
    while (sb_q.size() > 0) begin
      mon_e = sb_q.pop_front();
      n_vec++;
      n_bad++;
      $display("FAIL unchecked kind%0d port%0d due %0d: got none expected %h", mon_e.kind, mon_e.port, mon_e.due, mon_e.exp);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/rv32i_regfile_mp.md
RV32I_REGFILE_MP -- requirements
Module: rv32i_regfile_mp

Interface
REQ-001 SHALL have parameter XLEN, default 32: register data width in bits.
REQ-002 SHALL have parameter NREG, default 32: register count; legal values are 16 or 32 (RV32E/RV32I).
REQ-003 SHALL have parameter NRD, default 2: number of read ports, 1..4.
REQ-004 SHALL have port clk  input  1: single clock; all state updates on the rising edge.
REQ-005 SHALL have port reset  input  1: asynchronous, active-high reset.
REQ-006 SHALL have port wb_enable  input  1: write-back strobe.
REQ-007 SHALL have port wb_reg  input  $clog2(NREG): write-back register index.
REQ-008 SHALL have port wb_data  input  XLEN: write-back data.
REQ-009 SHALL have port rs_reg  input  NRD x $clog2(NREG): read index, one per port.
REQ-010 SHALL have port rs_data  output  NRD x XLEN: registered read data, one per port.
REQ-011 SHALL have port ready  output  1: high once the register-clear sequence is complete.

Function
REQ-012 SHALL implement a two-state FSM: INIT clears storage; READY is normal operation.
REQ-013 SHALL, in INIT, zero register idx on each edge, with idx counting 1..NREG-1; on the edge that clears NREG-1 it SHALL enter READY with ready=1.
REQ-014 SHALL hold ready low for exactly NREG-1 edges after reset deassertion (31 edges at NREG=32).
REQ-015 SHALL ignore wb_enable while in INIT.
REQ-016 SHALL drive all rs_data to 0 on every edge while in INIT.
REQ-017 SHALL, in READY, write wb_data to register wb_reg at the edge when wb_enable=1 and wb_reg!=0.
REQ-018 SHALL drop writes to x0; x0 SHALL always read as 0.
REQ-019 SHALL give every read port a latency of one edge: rs_data[i] at edge N reflects rs_reg[i] sampled at edge N.
REQ-020 SHALL apply write-first bypass: if wb_enable=1, wb_reg=rs_reg[i]!=0 and ready=1 at the same edge, rs_data[i] SHALL take wb_data.
REQ-021 SHALL allow any number of ports to read the same register in one cycle, each returning identical data.
REQ-022 SHALL hold rs_data stable between edges; there SHALL be no combinational path from inputs to rs_data.

Reset
REQ-023 SHALL on reset assertion immediately force the FSM to INIT, the clear counter to 1, ready=0 and all rs_data=0.
REQ-024 SHALL not reset storage directly; storage is zeroed only by the INIT sequence, so it maps to RAM.
REQ-025 SHALL restart the full INIT sequence from idx 1 if reset asserts mid-INIT or mid-READY.

Configuration
REQ-026 SHALL, with RV32I_REGFILE_DBG_EN defined, add dbg_reg (input, $clog2(NREG)) and dbg_data (output, XLEN), where dbg_data is combinational, returns 0 for x0, and has no bypass.
REQ-027 SHALL, without RV32I_REGFILE_DBG_EN, have neither dbg port nor any related logic.

Structure
REQ-028 SHALL take the XLEN default, legal NREG values and the FSM state enum (INIT, READY) from shared package rv32i_pkg.
REQ-029 SHALL implement each read port as sub-module rv32i_regfile_rdport, instantiated NRD times with a generate loop; it contains the bypass mux and output register.

Verification
REQ-030 SHALL verify: reset then count edges -> ready rises after exactly 31 edges; all rs_data=0 throughout INIT.
REQ-031 SHALL verify: in READY, write 0x25 to x10, then read x10 on port0 and x15 on port1 -> 0x00000025 and 0x00000000.
REQ-032 SHALL verify: write 321 to x0 and read x0 on port0 at the same edge -> port0 returns 0; a later read of x0 returns 0.
REQ-033 SHALL verify: write 0x20 to x5 while port0 and port1 both read x5 at the same edge -> both return 0x20 after one edge (bypass).
REQ-034 SHALL verify: write 0xDEADBEEF to x7, then assert reset after 5 INIT edges -> INIT restarts; after 31 edges ready=1 and x7 reads 0.
REQ-035 SHALL verify: with RV32I_REGFILE_DBG_EN and x3=0x1234 -> dbg_reg=3 gives dbg_data=0x1234 in the same cycle.
